// File: rtl/jk_ff_bank_multimode_pkg.sv
// rtl/jk_ff_bank_multimode_pkg.sv - shared mode encodings for the multimode flip-flop bank
package jk_ff_bank_multimode_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    localparam int DEFAULT_N     = 4;
    localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/jk_ff_bank_multimode_jk_bit_cell.sv
// rtl/jk_ff_bank_multimode_jk_bit_cell.sv - one state bit with saturating transition counter and sticky SR-illegal flag
module jk_bit_cell
    import jk_ff_bank_multimode_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic             j,
    input  logic             k,
    input  logic             d_load,
    input  logic             clr_flags,
    output logic             q,
    output logic             illegal,
    output logic [CNT_W-1:0] tcnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic next_q;
    logic sr_conflict;
    logic mode_op;

    assign mode_op = en && !load;

    always_comb begin
        next_q      = q;
        sr_conflict = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b01:   next_q = 1'b0;
                    2'b10:   next_q = 1'b1;
                    2'b11:   next_q = ~q;
                    default: next_q = q;
                endcase
            end
            MODE_D:  next_q = j;
            MODE_T:  next_q = q ^ j;
            default: begin
                case ({j, k})
                    2'b10:   next_q = 1'b1;
                    2'b01:   next_q = 1'b0;
                    2'b11:   sr_conflict = 1'b1;
                    default: next_q = q;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= 1'b0;
            tcnt <= '0;
        end else if (load) begin
            q <= d_load;
        end else if (en) begin
            q <= next_q;
            if ((next_q != q) && (tcnt != CNT_MAX)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // A fresh conflict on the same edge as clr_flags keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (mode_op && sr_conflict) begin
            illegal <= 1'b1;
        end else if (clr_flags) begin
            illegal <= 1'b0;
        end
    end

endmodule

// File: rtl/jk_ff_bank_multimode.sv
// rtl/jk_ff_bank_multimode.sv - N-bit run-time selectable JK/D/T/SR flip-flop bank
module jk_ff_bank_multimode
    import jk_ff_bank_multimode_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [N-1:0]       d_load,
    input  logic [N-1:0]       j,
    input  logic [N-1:0]       k,
    input  logic               clr_flags,
    output logic [N-1:0]       q,
    output logic [N-1:0]       q_bar,
    output logic [N-1:0]       illegal,
    output logic [N*CNT_W-1:0] tcnt
);

    assign q_bar = ~q;

    for (genvar i = 0; i < N; i++) begin : g_cell
        jk_bit_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .load      (load),
            .mode      (mode),
            .j         (j[i]),
            .k         (k[i]),
            .d_load    (d_load[i]),
            .clr_flags (clr_flags),
            .q         (q[i]),
            .illegal   (illegal[i]),
            .tcnt      (tcnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_jk_ff_bank_multimode.sv
// tb/tb_jk_ff_bank_multimode.sv - self-checking bench for jk_ff_bank_multimode
module tb_jk_ff_bank_multimode;

    logic        clk = 1'b0;
    logic        rst, en, load, clr_flags;
    logic [1:0]  mode;
    logic [3:0]  d_load, j, k;
    logic [3:0]  q, q_bar, illegal;
    logic [31:0] tcnt;

    int checks = 0;
    int errors = 0;

    jk_ff_bank_multimode #(.N(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .load      (load),
        .d_load    (d_load),
        .j         (j),
        .k         (k),
        .clr_flags (clr_flags),
        .q         (q),
        .q_bar     (q_bar),
        .illegal   (illegal),
        .tcnt      (tcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  mode;
        logic        load;
        logic [3:0]  d_load;
        logic [3:0]  j;
        logic [3:0]  k;
        logic        clr;
        logic [3:0]  eq;
        logic [3:0]  eill;
        logic [31:0] etcnt;
    } vec_t;

    vec_t vecs[12];

    task automatic apply(input logic r, input logic e, input logic [1:0] m, input logic l,
                         input logic [3:0] dl, input logic [3:0] jj, input logic [3:0] kk,
                         input logic c);
        rst = r; en = e; mode = m; load = l; d_load = dl; j = jj; k = kk; clr_flags = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [3:0] mq;
    int         mcnt[4];
    logic [3:0] prev_q;

    initial begin
        rst = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0;
        d_load = 4'h0; j = 4'h0; k = 4'h0; clr_flags = 1'b0;

        // Reset state
        apply(1, 0, 2'b00, 0, 4'h0, 4'h0, 4'h0, 0);
        apply(0, 0, 2'b00, 0, 4'h0, 4'h0, 4'h0, 0);
        chk("reset_q", {28'h0, q}, 32'h0);
        chk("reset_q_bar", {28'h0, q_bar}, 32'hF);
        chk("reset_illegal", {28'h0, illegal}, 32'h0);
        chk("reset_tcnt", tcnt, 32'h0);

        // Directed vectors: {rst,en,mode,load,d_load,j,k,clr} -> {q,illegal,tcnt}
        vecs[0]  = '{0, 0, 2'b00, 1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 32'h00000000};
        vecs[1]  = '{0, 1, 2'b10, 1, 4'b1010, 4'b1111, 4'b0000, 0, 4'b1010, 4'b0000, 32'h00000000};
        vecs[2]  = '{0, 1, 2'b01, 0, 4'b0000, 4'b0110, 4'b0000, 0, 4'b0110, 4'b0000, 32'h01010000};
        vecs[3]  = '{0, 1, 2'b11, 0, 4'b0000, 4'b0100, 4'b0100, 0, 4'b0110, 4'b0100, 32'h01010000};
        vecs[4]  = '{0, 1, 2'b11, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0110, 4'b0000, 32'h01010000};
        vecs[5]  = '{0, 1, 2'b11, 0, 4'b0000, 4'b0100, 4'b0100, 1, 4'b0110, 4'b0100, 32'h01010000};
        vecs[6]  = '{0, 1, 2'b11, 0, 4'b0000, 4'b0001, 4'b0010, 0, 4'b0101, 4'b0100, 32'h01010101};
        vecs[7]  = '{0, 0, 2'b01, 0, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0101, 4'b0100, 32'h01010101};
        vecs[8]  = '{0, 1, 2'b00, 0, 4'b0000, 4'b1000, 4'b0001, 0, 4'b1100, 4'b0100, 32'h02010102};
        vecs[9]  = '{0, 1, 2'b00, 0, 4'b0000, 4'b1111, 4'b1111, 0, 4'b0011, 4'b0100, 32'h03020203};
        vecs[10] = '{0, 1, 2'b10, 0, 4'b0000, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0100, 32'h03020304};
        vecs[11] = '{1, 1, 2'b01, 1, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 32'h00000000};

        for (int v = 0; v < 12; v++) begin
            apply(vecs[v].rst, vecs[v].en, vecs[v].mode, vecs[v].load,
                  vecs[v].d_load, vecs[v].j, vecs[v].k, vecs[v].clr);
            chk($sformatf("vec%0d_q", v), {28'h0, q}, {28'h0, vecs[v].eq});
            chk($sformatf("vec%0d_q_bar", v), {28'h0, q_bar}, {28'h0, ~vecs[v].eq});
            chk($sformatf("vec%0d_illegal", v), {28'h0, illegal}, {28'h0, vecs[v].eill});
            chk($sformatf("vec%0d_tcnt", v), tcnt, vecs[v].etcnt);
        end

        // JK sweep over every j/k pair from a known starting state
        apply(1, 0, 2'b00, 0, 4'h0, 4'h0, 4'h0, 0);
        apply(0, 0, 2'b00, 1, 4'b0101, 4'h0, 4'h0, 0);
        mq = 4'b0101;
        for (int b = 0; b < 4; b++) mcnt[b] = 0;
        for (int a = 0; a < 16; a++) begin
            for (int c = 0; c < 16; c++) begin
                logic [3:0] jj, kk, nq;
                jj = 4'(a);
                kk = 4'(c);
                for (int b = 0; b < 4; b++) begin
                    if (jj[b] && kk[b])       nq[b] = ~mq[b];
                    else if (jj[b])           nq[b] = 1'b1;
                    else if (kk[b])           nq[b] = 1'b0;
                    else                      nq[b] = mq[b];
                    if (nq[b] != mq[b] && mcnt[b] < 255) mcnt[b]++;
                end
                mq = nq;
                apply(0, 1, 2'b00, 0, 4'h0, jj, kk, 0);
                chk($sformatf("jk_q_j%0h_k%0h", jj, kk), {28'h0, q}, {28'h0, mq});
                chk($sformatf("jk_qbar_j%0h_k%0h", jj, kk), {28'h0, q_bar}, {28'h0, ~mq});
            end
        end
        chk("jk_sweep_tcnt", tcnt, {8'(mcnt[3]), 8'(mcnt[2]), 8'(mcnt[1]), 8'(mcnt[0])});
        chk("jk_sweep_illegal", {28'h0, illegal}, 32'h0);

        // T-mode counter saturation on bit 0
        apply(1, 0, 2'b00, 0, 4'h0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 300; i++) begin
            apply(0, 1, 2'b10, 0, 4'h0, 4'b0001, 4'h0, 0);
            if (i == 253) chk("tsat_tcnt_254", tcnt, 32'h000000FE);
            if (i == 254) chk("tsat_tcnt_255", tcnt, 32'h000000FF);
        end
        chk("tsat_tcnt_300", tcnt, 32'h000000FF);
        chk("tsat_q_300", {28'h0, q}, 32'h0);
        prev_q = q;
        apply(0, 1, 2'b10, 0, 4'h0, 4'b0001, 4'h0, 0);
        chk("tsat_q_toggles", {28'h0, q}, {28'h0, prev_q ^ 4'b0001});
        chk("tsat_tcnt_held", tcnt, 32'h000000FF);

        // Reset mid-sequence wins over load and discards counts
        apply(1, 1, 2'b10, 1, 4'b1111, 4'b1111, 4'h0, 0);
        chk("rst_mid_q", {28'h0, q}, 32'h0);
        chk("rst_mid_tcnt", tcnt, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
